// File: rtl/llki_mock_keymix_if.sv
// Key-load and key-erase channel between a key source and llki_mock_keymix.
// The source drives valid/data/last/clear_req; the unit answers with ready/clear_ack.
interface llki_mock_keymix_if #(
    parameter int WORD_W = 64
);
    logic              load_valid;
    logic              load_ready;
    logic [WORD_W-1:0] load_data;
    logic              load_last;
    logic              clear_req;
    logic              clear_ack;

    modport master (
        output load_valid, load_data, load_last, clear_req,
        input  load_ready, clear_ack
    );

    modport slave (
        input  load_valid, load_data, load_last, clear_req,
        output load_ready, clear_ack
    );
endinterface

// File: rtl/llki_mock_keymix.sv
// Mock LLKI key mixer: stores a multi-word key and, once armed, XORs the core key
// with (EXP_KEY ^ stored key) so that only the correct key leaves key_in unchanged.
module llki_mock_keymix #(
    parameter int                          KEY_WORDS  = 2,
    parameter int                          WORD_W     = 64,
    parameter int                          CORE_KEY_W = 56,
    parameter logic [KEY_WORDS*WORD_W-1:0] EXP_KEY    = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    llki_mock_keymix_if.slave     ld,
    input  logic                  start,
    input  logic [CORE_KEY_W-1:0] key_in,
    output logic [CORE_KEY_W-1:0] key_out,
    output logic                  key_loaded,
    output logic                  key_error,
    output logic                  armed
);
    localparam int KEY_W = KEY_WORDS * WORD_W;
    localparam int IDX_W = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(KEY_WORDS - 1);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_LOADING,
        ST_LOADED,
        ST_CLEARING
    } state_e;

    state_e                           state_q, state_d;
    logic [IDX_W-1:0]                 idx_q, idx_d;
    logic [KEY_WORDS-1:0][WORD_W-1:0] words_q;
    logic                             key_error_q;
    logic                             armed_q, armed_d;
    logic                             clear_ack_q;

    logic             accept;
    logic             last_idx;
    logic             wr_en;
    logic             zero_all;
    logic             err_set;
    logic             err_clr;
    logic             ack_d;
    logic [KEY_W-1:0] act_key;
    logic [CORE_KEY_W-1:0] mask;

    // Ready is forced low while reset is held so nothing is offered during reset.
    assign ld.load_ready = reset_n && !ld.clear_req &&
                           (state_q == ST_EMPTY || state_q == ST_LOADING);
    assign accept   = ld.load_valid && ld.load_ready;
    assign last_idx = (idx_q == LAST_IDX);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        wr_en    = 1'b0;
        zero_all = 1'b0;
        err_set  = 1'b0;
        err_clr  = 1'b0;
        ack_d    = 1'b0;
        armed_d  = armed_q;

        if (ld.clear_req) begin
            state_d  = ST_CLEARING;
            idx_d    = '0;
            zero_all = 1'b1;
            err_clr  = 1'b1;
        end else begin
            unique case (state_q)
                ST_EMPTY, ST_LOADING: begin
                    if (accept) begin
                        wr_en = 1'b1;
                        if (state_q == ST_EMPTY) err_clr = 1'b1;
                        if (ld.load_last && last_idx) begin
                            state_d = ST_LOADED;
                        end else if (ld.load_last || last_idx) begin
                            // Framing broken: drop everything collected so far.
                            state_d  = ST_EMPTY;
                            idx_d    = '0;
                            zero_all = 1'b1;
                            err_set  = 1'b1;
                        end else begin
                            state_d = ST_LOADING;
                            idx_d   = idx_q + IDX_W'(1);
                        end
                    end
                end
                ST_LOADED: begin
                    state_d = ST_LOADED;
                end
                ST_CLEARING: begin
                    state_d  = ST_EMPTY;
                    zero_all = 1'b1;
                    ack_d    = 1'b1;
                end
                default: state_d = ST_EMPTY;
            endcase
        end

        if (ld.clear_req || state_q == ST_CLEARING) armed_d = 1'b0;
        else if (start)                             armed_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_EMPTY;
            idx_q       <= '0;
            key_error_q <= 1'b0;
            armed_q     <= 1'b0;
            clear_ack_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            armed_q     <= armed_d;
            clear_ack_q <= ack_d;
            if (err_set)      key_error_q <= 1'b1;
            else if (err_clr) key_error_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            words_q <= '0;
        end else if (zero_all) begin
            words_q <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < KEY_WORDS; i++) begin
                if (idx_q == IDX_W'(i)) words_q[i] <= ld.load_data;
            end
        end
    end

    // Word 0 sits in the MSBs of the assembled key.
    for (genvar i = 0; i < KEY_WORDS; i++) begin : g_act
        assign act_key[(KEY_WORDS-1-i)*WORD_W +: WORD_W] = words_q[i];
    end

    if (CORE_KEY_W < KEY_W) begin : g_unused
        logic unused_hi;
        assign unused_hi = ^act_key[KEY_W-1:CORE_KEY_W];
    end

    assign mask         = EXP_KEY[CORE_KEY_W-1:0] ^ act_key[CORE_KEY_W-1:0];
    assign key_out      = armed_q ? (key_in ^ mask) : key_in;
    assign key_loaded   = (state_q == ST_LOADED);
    assign key_error    = key_error_q;
    assign armed        = armed_q;
    assign ld.clear_ack = clear_ack_q;

endmodule

// File: tb/tb_llki_mock_keymix.sv
// Directed + randomized bench for llki_mock_keymix against a word-list key model.
module tb_llki_mock_keymix;
    localparam int KW  = 2;
    localparam int WW  = 64;
    localparam int CKW = 56;
    localparam logic [KW*WW-1:0] EXP = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           start = 1'b0;
    logic [CKW-1:0] key_in = '0;
    logic [CKW-1:0] key_out;
    logic           key_loaded, key_error, armed;

    llki_mock_keymix_if #(.WORD_W(WW)) lif ();

    llki_mock_keymix #(
        .KEY_WORDS(KW), .WORD_W(WW), .CORE_KEY_W(CKW), .EXP_KEY(EXP)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ld(lif), .start(start), .key_in(key_in),
        .key_out(key_out), .key_loaded(key_loaded), .key_error(key_error), .armed(armed)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [KW*WW-1:0] exp_v = EXP;
    logic [WW-1:0]    m_w [KW];
    int               m_cnt;
    bit               m_loaded, m_err, m_armed, m_clr, m_ack;

    function automatic logic [WW-1:0] exp_word(input int p);
        return exp_v[(KW-1-p)*WW +: WW];
    endfunction

    task automatic m_reset();
        for (int i = 0; i < KW; i++) m_w[i] = '0;
        m_cnt = 0; m_loaded = 0; m_err = 0; m_armed = 0; m_clr = 0; m_ack = 0;
    endtask

    task automatic m_zero();
        for (int i = 0; i < KW; i++) m_w[i] = '0;
        m_cnt = 0;
    endtask

    // Advance the model by one clock using the inputs held across the edge.
    task automatic m_step();
        bit acc;
        acc = lif.load_valid && !m_loaded && !m_clr && !lif.clear_req;
        if (lif.clear_req) begin
            m_zero(); m_err = 0; m_armed = 0; m_loaded = 0; m_clr = 1; m_ack = 0;
        end else if (m_clr) begin
            m_clr = 0; m_ack = 1;
        end else begin
            m_ack = 0;
            if (start) m_armed = 1;
            if (acc) begin
                m_w[m_cnt] = lif.load_data;
                m_err = 0;
                if (lif.load_last && m_cnt == KW-1) m_loaded = 1;
                else if (lif.load_last || m_cnt == KW-1) begin m_zero(); m_err = 1; end
                else m_cnt++;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all();
        logic [KW*WW-1:0] act;
        logic [CKW-1:0]   mask;
        for (int i = 0; i < KW; i++) act[(KW-1-i)*WW +: WW] = m_w[i];
        mask = exp_v[CKW-1:0] ^ act[CKW-1:0];
        chk("key_out",    64'(key_out),        64'(m_armed ? (key_in ^ mask) : key_in));
        chk("load_ready", 64'(lif.load_ready), 64'(reset_n && !m_loaded && !m_clr && !lif.clear_req));
        chk("key_loaded", 64'(key_loaded),     64'(m_loaded));
        chk("key_error",  64'(key_error),      64'(m_err));
        chk("armed",      64'(armed),          64'(m_armed));
        chk("clear_ack",  64'(lif.clear_ack),  64'(m_ack));
    endtask

    task automatic cyc();
        @(posedge clk);
        if (reset_n) m_step();
        #1;
        chk_all();
    endtask

    task automatic set_key(input logic [CKW-1:0] v);
        key_in = v;
        #1;
        chk_all();
    endtask

    task automatic send(input logic [WW-1:0] d, input bit last);
        lif.load_valid = 1'b1; lif.load_data = d; lif.load_last = last;
        cyc();
        lif.load_valid = 1'b0; lif.load_last = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; cyc(); start = 1'b0;
    endtask

    task automatic do_clear();
        lif.clear_req = 1'b1; cyc(); lif.clear_req = 1'b0; cyc(); cyc();
    endtask

    initial begin
        lif.load_valid = 1'b0; lif.load_data = '0; lif.load_last = 1'b0; lif.clear_req = 1'b0;
        m_reset();

        // Reset values, then release.
        key_in = 56'({$urandom, $urandom});
        #1 chk_all();
        cyc(); cyc();
        reset_n = 1'b1;
        #1 chk_all();
        chk("ready_after_reset", 64'(lif.load_ready), 64'd1);

        // No key loaded: passthrough until start, then full EXP corruption.
        set_key(56'({$urandom, $urandom}));
        chk("noload_pass", 64'(key_out), 64'(key_in));
        pulse_start();
        chk("noload_mix", 64'(key_out ^ key_in), 64'h00DC_BA98_7654_3210);
        do_clear();

        // Correct key, then clear and start in the same cycle.
        send(exp_word(0), 1'b0);
        send(exp_word(1), 1'b1);
        chk("loaded_after_last", 64'(key_loaded), 64'd1);
        lif.clear_req = 1'b1; start = 1'b1;
        cyc();
        lif.clear_req = 1'b0; start = 1'b0;
        chk("clear_start_not_armed", 64'(armed), 64'd0);
        cyc();
        chk("clear_ack_pulse", 64'(lif.clear_ack), 64'd1);
        cyc();

        // Reload correct key and arm: key passes unchanged.
        send(exp_word(0), 1'b0);
        send(exp_word(1), 1'b1);
        pulse_start();
        set_key(56'h1133_5577_99BB_DD);
        chk("match_pass", 64'(key_out), 64'h0011_3355_7799_BBDD);
        for (int i = 0; i < 4; i++) begin set_key(56'({$urandom, $urandom})); cyc(); end
        do_clear();

        // Word 1 wrong (zero): low bits of EXP word 1 leak into key_out.
        send(exp_word(0), 1'b0);
        send('0, 1'b1);
        pulse_start();
        set_key(56'h1133_5577_99BB_DD);
        chk("w1_zero_mix", 64'(key_out), 64'(56'h1133_5577_99BB_DD ^ 56'hDC_BA98_7654_3210));
        do_clear();

        // Early load_last on word 0: error, key discarded, next word clears error.
        send(exp_word(0), 1'b1);
        chk("early_last_err", 64'(key_error), 64'd1);
        chk("early_last_notloaded", 64'(key_loaded), 64'd0);
        pulse_start();
        set_key(56'({$urandom, $urandom}));
        chk("err_words_zero", 64'(key_out ^ key_in), 64'h00DC_BA98_7654_3210);
        send(64'({$urandom, $urandom}), 1'b0);
        chk("err_cleared", 64'(key_error), 64'd0);
        do_clear();

        // Asynchronous reset in the middle of a load.
        send(exp_word(0), 1'b0);
        #2 reset_n = 1'b0;
        m_reset();
        #1 chk_all();
        chk("async_rst_ready", 64'(lif.load_ready), 64'd0);
        cyc();
        reset_n = 1'b1;
        #1 chk_all();
        send(exp_word(0), 1'b0);
        send(exp_word(1), 1'b1);
        pulse_start();
        set_key(56'({$urandom, $urandom}));
        chk("reload_pass", 64'(key_out), 64'(key_in));
        do_clear();

        // Random traffic against the model.
        for (int n = 0; n < 300; n++) begin
            lif.load_valid = ($urandom_range(0, 3) != 0);
            lif.load_data  = ($urandom_range(0, 1) != 0) ? exp_word(m_cnt < KW ? m_cnt : 0)
                                                         : 64'({$urandom, $urandom});
            lif.load_last  = ($urandom_range(0, 4) != 0) ? (m_cnt == KW-1) : (m_cnt != KW-1);
            lif.clear_req  = ($urandom_range(0, 15) == 0);
            start          = ($urandom_range(0, 7) == 0);
            key_in         = 56'({$urandom, $urandom});
            #1 chk_all();
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
